// File: rtl/ysyx_22040895_memarb.sv
// ============================================================================
//  Module   : ysyx_22040895_memarb
//  Brief    : IFU/LSU arbiter for the single memory port, one outstanding
//             transaction, response routing and response timeout.
//             Build option YSYX_22040895_MEMARB_RR_EN selects round-robin.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22040895_memarb #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_req_ready,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    input  logic                lsu_req_valid,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_req_ready,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                mem_req_valid,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                owner_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt;

    logic w_idle, w_wait, w_sel, w_fire, w_timeout, w_done;

    // Gating with rst keeps every output quiet while reset is held.
    assign w_idle = rst && (r_state == IDLE);
    assign w_wait = rst && (r_state == WAIT);

`ifdef YSYX_22040895_MEMARB_RR_EN
    assign w_sel = (ifu_req_valid && lsu_req_valid) ? ~r_last_grant : lsu_req_valid;
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = r_last_grant;
    assign w_sel               = lsu_req_valid;
`endif

    assign mem_req_valid = w_idle && (ifu_req_valid || lsu_req_valid);
    assign mem_req_addr  = !w_idle ? '0 : (w_sel ? lsu_req_addr : ifu_req_addr);
    assign mem_req_wen   = w_idle && w_sel && lsu_req_wen;
    assign mem_req_wdata = (w_idle && w_sel) ? lsu_req_wdata : '0;
    assign mem_req_wmask = (w_idle && w_sel) ? lsu_req_wmask : '0;

    assign w_fire        = mem_req_valid && mem_req_ready;
    assign ifu_req_ready = w_fire && !w_sel;
    assign lsu_req_ready = w_fire && w_sel;

    // A real response in the timeout cycle takes precedence over the error.
    assign w_timeout = (TIMEOUT != 0) && w_wait && (r_cnt == c_TIMEOUT) && !mem_rsp_valid;
    assign w_done    = w_wait && (mem_rsp_valid || w_timeout);

    assign ifu_rsp_valid = w_done && !r_owner;
    assign lsu_rsp_valid = w_done && r_owner;
    assign ifu_rsp_data  = (w_wait && mem_rsp_valid && !r_owner) ? mem_rsp_data : '0;
    assign lsu_rsp_data  = (w_wait && mem_rsp_valid && r_owner) ? mem_rsp_data : '0;

    assign owner_o = r_owner;
    assign busy_o  = w_wait;
    assign err_o   = w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_state      <= WAIT;
                        r_owner      <= w_sel;
                        r_last_grant <= w_sel;
                        r_cnt        <= '0;
                    end
                end
                WAIT: begin
                    if (w_done) r_state <= IDLE;
                    else        r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040895_memarb.sv
// ============================================================================
//  Module   : tb_ysyx_22040895_memarb
//  Brief    : Directed + randomized transaction bench with a transaction-level
//             reference model for the memory arbiter (TIMEOUT = 4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22040895_memarb;

    localparam int TO = 4;
`ifdef YSYX_22040895_MEMARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [63:0] ifu_req_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_rsp_valid;
    logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
    logic [7:0]  lsu_req_wmask, mem_req_wmask;
    logic        mem_req_valid, mem_req_wen, mem_req_ready, mem_rsp_valid;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic        owner_o, busy_o, err_o;

    int checks = 0;
    int errors = 0;
    bit m_last = 1'b0;  // requester granted most recently (1 = LSU)

    always #5 clk = ~clk;

    ysyx_22040895_memarb #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
        .ifu_req_ready(ifu_req_ready), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata),
        .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
        .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // One complete transaction: request (with stall cycles of back-pressure),
    // then WAIT until a response at WAIT cycle 'lat' or the timeout.
    task automatic txn(input bit iv, input bit lv, input logic [63:0] ia, input logic [63:0] la,
                       input bit wen, input logic [63:0] wd, input logic [7:0] wm,
                       input int stall, input int lat, input logic [63:0] rdat);
        bit s, rsp, to;
        if (!iv && !lv) return;
        if (iv && lv) s = RR ? !m_last : 1'b1;
        else          s = lv;
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            ifu_req_valid = iv; ifu_req_addr = ia;
            lsu_req_valid = lv; lsu_req_addr = la; lsu_req_wen = wen;
            lsu_req_wdata = wd; lsu_req_wmask = wm;
            mem_req_ready = (i == stall); mem_rsp_valid = 1'b0;
            #1;
            chkb("busy_idle", busy_o, 1'b0);
            chkb("mem_req_valid", mem_req_valid, 1'b1);
            chkb("ifu_req_ready", ifu_req_ready, (i == stall) && !s);
            chkb("lsu_req_ready", lsu_req_ready, (i == stall) && s);
        end
        chk("mem_req_addr", mem_req_addr, s ? la : ia);
        chkb("mem_req_wen", mem_req_wen, s && wen);
        chk("mem_req_wdata", mem_req_wdata, s ? wd : 64'h0);
        chk("mem_req_wmask", 64'(mem_req_wmask), s ? 64'(wm) : 64'h0);
        m_last = s;
        for (int k = 0; k <= TO; k++) begin
            @(negedge clk);
            ifu_req_valid = 1'($urandom); lsu_req_valid = 1'($urandom);
            mem_req_ready = 1'($urandom);
            mem_rsp_valid = (k == lat); mem_rsp_data = rdat;
            rsp = (k == lat);
            to  = !rsp && (k == TO);
            #1;
            chkb("busy_wait", busy_o, 1'b1);
            chkb("owner_o", owner_o, s);
            chkb("mem_req_valid_wait", mem_req_valid, 1'b0);
            chkb("ifu_req_ready_wait", ifu_req_ready, 1'b0);
            chkb("lsu_req_ready_wait", lsu_req_ready, 1'b0);
            chkb("err_o", err_o, to);
            chkb("ifu_rsp_valid", ifu_rsp_valid, (rsp || to) && !s);
            chkb("lsu_rsp_valid", lsu_rsp_valid, (rsp || to) && s);
            if (s) chk("ifu_rsp_data_idle", ifu_rsp_data, 64'h0);
            else   chk("lsu_rsp_data_idle", lsu_rsp_data, 64'h0);
            if (!(s && wen && rsp))
                chk("owner_rsp_data", s ? lsu_rsp_data : ifu_rsp_data, rsp ? rdat : 64'h0);
            if (rsp || to) break;
        end
    endtask

    // Idle cycle with a stray response that must be ignored.
    task automatic idle_rsp(input logic [63:0] d);
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'($urandom);
        mem_rsp_valid = 1'b1; mem_rsp_data = d;
        #1;
        chkb("idle_busy", busy_o, 1'b0);
        chkb("idle_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        chkb("idle_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        chkb("idle_err", err_o, 1'b0);
        chkb("idle_mem_req_valid", mem_req_valid, 1'b0);
        chk("idle_ifu_rsp_data", ifu_rsp_data, 64'h0);
        chk("idle_lsu_rsp_data", lsu_rsp_data, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0000;
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_1000; lsu_req_wen = 1'b1;
        lsu_req_wdata = 64'hFFFF; lsu_req_wmask = 8'hFF;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1234;
        repeat (2) @(negedge clk);
        #1;
        chkb("rst_mem_req_valid", mem_req_valid, 1'b0);
        chkb("rst_ifu_req_ready", ifu_req_ready, 1'b0);
        chkb("rst_lsu_req_ready", lsu_req_ready, 1'b0);
        chkb("rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        chkb("rst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        chkb("rst_busy", busy_o, 1'b0);
        chkb("rst_err", err_o, 1'b0);
        chkb("rst_owner", owner_o, 1'b0);
        chk("rst_mem_req_addr", mem_req_addr, 64'h0);
        chk("rst_mem_req_wdata", mem_req_wdata, 64'h0);

        // Reset in the middle of an IFU fetch drops the transaction.
        @(negedge clk);
        rst = 1'b1; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        chkb("rr_ifu_req_ready", ifu_req_ready, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        #1;
        chkb("rr_busy_wait", busy_o, 1'b1);
        rst = 1'b0;
        #1;
        chkb("rr_busy_in_reset", busy_o, 1'b0);
        chkb("rr_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        chkb("rr_mem_req_valid", mem_req_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_last = 1'b0;
        idle_rsp(64'hDEAD);

        // Single fetch, response three cycles after the first WAIT cycle.
        txn(1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 8'h0, 0, 3, 64'h0000_0413);
        // Contention with single-cycle memory.
        for (int i = 0; i < 4; i++)
            txn(1, 1, 64'h8000_0000 + 64'(4 * i), 64'h8000_2000 + 64'(8 * i), 0, 64'h0, 8'h0,
                0, 0, {$urandom, $urandom});
        txn(1, 0, 64'h8000_0010, 64'h0, 0, 64'h0, 8'h0, 0, 0, 64'h55);
        // Store.
        txn(0, 1, 64'h0, 64'h8000_1008, 1, 64'h1122_3344_5566_7788, 8'hF0, 0, 1, 64'h0);
        // Back-pressure for four cycles.
        txn(1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 8'h0, 4, 2, 64'hABCD);
        // Timeout with a late response afterwards.
        txn(1, 0, 64'h8000_0004, 64'h0, 0, 64'h0, 8'h0, 0, 20, 64'h77);
        idle_rsp(64'hBEEF);
        // Response and timeout in the same cycle: the response wins.
        txn(0, 1, 64'h0, 64'h8000_3000, 0, 64'h0, 8'h0, 0, TO, 64'h9999);

        for (int n = 0; n < 60; n++) begin
            bit iv, lv;
            iv = 1'($urandom); lv = 1'($urandom);
            if (!iv && !lv) idle_rsp({$urandom, $urandom});
            else txn(iv, lv, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                     {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 6), {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
